// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one combinational 8x8 unsigned multiplier among NREQ requesters.
// One operation in flight: IDLE grants and latches operands, MUL captures the product, DONE holds it.

module mult (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] x
);
  assign x = a * b;
endmodule

module mult_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [8*NREQ-1:0]   req_a,
  input  logic [8*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [15:0]         rsp_x,
  output logic [IDW-1:0]      rsp_id,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t          state_reg, state_next;
  logic [7:0]      a_reg, b_reg;
  logic [IDW-1:0]  id_reg;
  logic [IDW-1:0]  rr_ptr_reg;
  logic [15:0]     rsp_x_reg;
  logic [IDW-1:0]  rsp_id_reg;

  logic            grant_any;
  logic [IDW-1:0]  grant_id;
  logic            grant_en;
  logic            accept;
  logic [7:0]      a_sel, b_sel;
  logic [15:0]     prod;
  int              idx;

  mult u_mult (
    .a (a_reg),
    .b (b_reg),
    .x (prod)
  );

  // Scan offsets from highest to lowest so the requester closest to rr_ptr wins last.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (i == idx && req_valid[i]) begin
          grant_any = 1'b1;
          grant_id  = IDW'(i);
        end
      end
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) begin
        a_sel = req_a[8*i +: 8];
        b_sel = req_b[8*i +: 8];
      end
    end
  end

  assign accept = |(rsp_valid & rsp_ready);

  always_comb begin
    state_next = state_reg;
    grant_en   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_any) begin
          grant_en   = 1'b1;
          state_next = MUL;
        end
      end
      MUL:  state_next = DONE;
      DONE: if (accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Reset wins over any handshake presented in the same cycle.
    if (rst) grant_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      id_reg     <= '0;
      rr_ptr_reg <= '0;
      rsp_x_reg  <= '0;
      rsp_id_reg <= '0;
    end else begin
      if (grant_en) begin
        a_reg      <= a_sel;
        b_reg      <= b_sel;
        id_reg     <= grant_id;
        rr_ptr_reg <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
      end
      // rsp_id only moves with rsp_x so both keep describing the last result.
      if (state_reg == MUL) begin
        rsp_x_reg  <= prod;
        rsp_id_reg <= id_reg;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_port
      assign req_ready[gi] = grant_en && (grant_id == IDW'(gi));
      assign rsp_valid[gi] = (state_reg == DONE) && (rsp_id_reg == IDW'(gi));
    end
  endgenerate

  assign rsp_x  = rsp_x_reg;
  assign rsp_id = rsp_id_reg;
  assign busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: stimulus pushes expected results, a monitor pops them on accept.

module tb_mult_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [8*NREQ-1:0] req_a, req_b;
  logic [15:0]       rsp_x;
  logic [IDW-1:0]    rsp_id;
  logic              busy;

  typedef struct {
    int          id;
    logic [15:0] x;
  } exp_t;

  exp_t sb_q[$];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  int   cyc      = 0;
  int   last_grant = 0;

  mult_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_x     (rsp_x),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Waits for the next grant, checks it is the expected one-hot and optionally queues the result.
  task automatic wait_grant(input int id, input logic [15:0] x, input bit push, input bit now,
                            input string nm);
    int n;
    logic [3:0] m;
    m = 4'b0001 << id;
    n = 0;
    if (!now) @(negedge clk);
    while (req_ready == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(req_ready), 32'(m));
    last_grant = cyc;
    if (push) sb_q.push_back('{id, x});
    $display("grant cycle=%0d req_ready=%b expected_id=%0d", cyc, req_ready, id);
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 20);
    check("drain_busy", 32'(busy), 32'(0));
  endtask

  // Monitor: every accepted response is compared against the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && (rsp_valid & rsp_ready) != '0) begin
      if (sb_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_rsp: got id=%0d x=%0h, expected none", rsp_id, rsp_x);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_x", 32'(rsp_x), 32'(e.x));
        check("rsp_valid", 32'(rsp_valid), 32'(4'b0001 << e.id));
        $display("rsp cycle=%0d id=%0d x=%0d expected id=%0d x=%0d", cyc, rsp_id, rsp_x, e.id, e.x);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  int rr_x [4] = '{10, 22, 36, 52};
  int t6_p [6] = '{0, 1, 2, 3, 2, 2};
  int t6_a [6] = '{0, 255, 1, 128, 255, 16};
  int t6_b [6] = '{0, 1, 255, 2, 255, 16};
  int t6_x [6] = '{0, 255, 255, 256, 65025, 256};

  initial begin
    int prev;
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '0;

    // Reset held with every requester asking
    repeat (2) begin
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'(0));
      check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_rsp_x", 32'(rsp_x), 32'(0));
      check("rst_rsp_id", 32'(rsp_id), 32'(0));
    end

    // Single op on requester 2: 13*11 = 143, visible two cycles after handshake
    @(posedge clk); #1;
    rst         = 1'b0;
    req_valid   = 4'b0100;
    req_a[23:16] = 8'd13;
    req_b[23:16] = 8'd11;
    rsp_ready   = 4'b0100;
    wait_grant(2, 16'd143, 1'b1, 1'b0, "t2_grant");
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("t2_busy_mul", 32'(busy), 32'(1));
    check("t2_ready_mul", 32'(req_ready), 32'(0));
    @(negedge clk);
    check("t2_rsp_valid", 32'(rsp_valid), 32'(4'b0100));
    check("t2_rsp_x", 32'(rsp_x), 32'(143));
    check("t2_rsp_id", 32'(rsp_id), 32'(2));
    @(negedge clk);
    check("t2_idle", 32'(busy), 32'(0));

    // Round robin from a fresh reset: 0,1,2,3,0 every 3 cycles
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    req_a     = {8'd4, 8'd3, 8'd2, 8'd1};
    req_b     = {8'd13, 8'd12, 8'd11, 8'd10};
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    wait_grant(0, 16'(rr_x[0]), 1'b1, 1'b0, "t3_grant");
    for (int k = 1; k <= 4; k++) begin
      prev = last_grant;
      wait_grant(k % 4, 16'(rr_x[k % 4]), 1'b1, 1'b0, "t3_grant");
      check("t3_interval", 32'(last_grant - prev), 32'(3));
    end
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Backpressure on requester 1 with 255*255 while requester 0 waits
    @(posedge clk); #1;
    req_a[15:8] = 8'd255;
    req_b[15:8] = 8'd255;
    req_valid   = 4'b0010;
    rsp_ready   = 4'b0001;
    wait_grant(1, 16'hFE01, 1'b1, 1'b0, "t4_grant");
    @(posedge clk); #1;
    req_valid = 4'b0001;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("t4_no_grant", 32'(req_ready), 32'(0));
      if (i >= 1) begin
        check("t4_rsp_valid", 32'(rsp_valid), 32'(4'b0010));
        check("t4_rsp_x", 32'(rsp_x), 32'(16'hFE01));
      end
    end
    @(posedge clk); #1;
    rsp_ready = 4'b0011;
    wait_grant(0, 16'd10, 1'b1, 1'b0, "t4_next_grant");
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = 4'b1111;
    drain();

    // Reset during MUL discards the op and returns rr_ptr to 0
    @(posedge clk); #1;
    req_a[31:24] = 8'd7;
    req_b[31:24] = 8'd9;
    req_valid    = 4'b1000;
    wait_grant(3, 16'd63, 1'b0, 1'b0, "t5_grant");
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("t5_rsp_valid_rst", 32'(rsp_valid), 32'(0));
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = 4'b1001;
    @(negedge clk);
    check("t5_rsp_valid_after", 32'(rsp_valid), 32'(0));
    check("t5_busy_after", 32'(busy), 32'(0));
    wait_grant(0, 16'd10, 1'b1, 1'b1, "t5_grant0");
    @(posedge clk); #1;
    req_valid = 4'b1000;
    wait_grant(3, 16'd63, 1'b1, 1'b0, "t5_grant3");
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Single-requester vectors including operand extremes
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      req_a[8*t6_p[i] +: 8] = 8'(t6_a[i]);
      req_b[8*t6_p[i] +: 8] = 8'(t6_b[i]);
      req_valid = 4'b0001 << t6_p[i];
      wait_grant(t6_p[i], 16'(t6_x[i]), 1'b1, 1'b0, "t6_grant");
      @(posedge clk); #1;
      req_valid = '0;
      drain();
    end

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'(0));
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
